// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : Data-side load/store unit between an RV32I execute stage and a
//             word-wide data RAM (async read, full-word sync write). Checks
//             alignment, address range and funct3; extracts and extends
//             LB/LH/LW/LBU/LHU data; performs SB/SH as a two-cycle
//             read-modify-write.
//  Ports    : clk, rst_n                 - clock, async active-low reset
//             req_valid/req_ready        - core request handshake
//             req_we, req_funct3         - store flag, RV32I access size
//             req_addr, req_wdata        - byte address, store data
//             resp_valid/resp_ready      - core response handshake
//             resp_rdata, resp_err       - load result, fault flag
//             ram_write_control/ram_addr/ram_write_data - RAM write side
//             ram_out                    - RAM combinational read data
//  Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int MEM_WORDS = 101
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        ram_write_control,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_write_data,
  input  logic [31:0] ram_out
);

  localparam logic [31:0] c_ADDR_LIMIT = 32'(4 * MEM_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RMW  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_addr;
  logic [31:0] r_merge;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;

  logic        w_accept;
  logic        w_is_b;
  logic        w_is_h;
  logic        w_is_w;
  logic        w_fault;
  logic        w_sw_go;
  logic        w_sub_store;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [31:0] w_merge;

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  assign req_ready = (r_state == S_IDLE);
  assign w_accept  = req_valid & req_ready;

  assign w_is_b = (req_funct3 == 3'b000) || (req_funct3 == 3'b100);
  assign w_is_h = (req_funct3 == 3'b001) || (req_funct3 == 3'b101);
  assign w_is_w = (req_funct3 == 3'b010);

  // Unsigned variants (funct3[2]) are meaningless for stores. The range check
  // is a full 32-bit compare so high addresses never alias into the RAM.
  assign w_fault = ~(w_is_b | w_is_h | w_is_w)
                 | (w_is_h & req_addr[0])
                 | (w_is_w & (req_addr[1:0] != 2'b00))
                 | (req_we & req_funct3[2])
                 | (req_addr >= c_ADDR_LIMIT);

  assign w_sw_go     = w_accept & req_we & w_is_w & ~w_fault;
  assign w_sub_store = w_accept & req_we & ~w_is_w & ~w_fault;

  // --------------------------------------------------------------------------
  // Load extraction (little-endian lanes)
  // --------------------------------------------------------------------------
  always_comb begin
    w_byte = ram_out[{req_addr[1:0], 3'b000} +: 8];
    w_half = req_addr[1] ? ram_out[31:16] : ram_out[15:0];
    case (req_funct3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load_data = {24'd0, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b101:  w_load_data = {16'd0, w_half};
      3'b010:  w_load_data = ram_out;
      default: w_load_data = 32'd0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Sub-word store merge: current word with one lane replaced
  // --------------------------------------------------------------------------
  always_comb begin
    w_merge = ram_out;
    if (w_is_h) begin
      if (req_addr[1]) w_merge[31:16] = req_wdata[15:0];
      else             w_merge[15:0]  = req_wdata[15:0];
    end else begin
      w_merge[{req_addr[1:0], 3'b000} +: 8] = req_wdata[7:0];
    end
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = w_sub_store ? S_RMW : S_RESP;
      end
      S_RMW:  w_state_next = S_RESP;
      S_RESP: begin
        if (resp_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr       <= 32'd0;
      r_merge      <= 32'd0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
    end else if (w_accept) begin
      r_addr       <= {req_addr[31:2], 2'b00};
      r_merge      <= w_merge;
      r_resp_err   <= w_fault;
      r_resp_rdata <= (w_fault || req_we) ? 32'd0 : w_load_data;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

  assign ram_addr       = (r_state == S_IDLE) ? {req_addr[31:2], 2'b00} : r_addr;
  assign ram_write_data = (r_state == S_IDLE) ? req_wdata : r_merge;

  // Gated by rst_n so an in-flight RMW write is dropped the moment reset hits.
  assign ram_write_control = rst_n & (w_sw_go | (r_state == S_RMW));

endmodule
`default_nettype wire
